pulse_meas: RTL
===============

PULSE_MEAS -- requirements
Module: pulse_meas

Interface
REQ-001 Parameter CNT_W, default 24, sets the width of the period and width counters and results.
REQ-002 Parameter SYNC_STAGES, default 2, sets the number of input synchronizer flops (minimum 2).
REQ-003 i_clk  input  1  the single clock (100 MHz pulse-domain clock).
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_en  input  1  measurement enable, level.
REQ-006 i_sig  input  1  asynchronous pulse input under measurement.
REQ-007 i_ack  input  1  one-cycle consumer acknowledge of the current result.
REQ-008 o_period  output  CNT_W  cycles between successive accepted rising edges.
REQ-009 o_width  output  CNT_W  cycles from an accepted rising edge to the following accepted falling edge.
REQ-010 o_valid  output  1  result pending, held until acknowledged.
REQ-011 o_ovf  output  1  sticky flag: a new result overwrote an unacknowledged one.
REQ-012 o_timeout  output  1  sticky flag: the counter saturated before the next rising edge.

Function
REQ-013 i_sig shall pass through SYNC_STAGES flops; an edge is accepted in the cycle the synchronized value differs from its registered previous value.
REQ-014 FSM states: IDLE, HIGH, LOW.
REQ-015 IDLE -> HIGH on an accepted rising edge while i_en=1; the counter loads 1.
REQ-016 HIGH -> LOW on an accepted falling edge; the captured width equals the counter value in that cycle.
REQ-017 LOW -> HIGH on an accepted rising edge; o_period takes the counter value and o_width takes the captured width, o_valid=1 on the next cycle, and the counter reloads 1.
REQ-018 The counter shall increment by 1 per cycle in HIGH and LOW, and saturate at 2^CNT_W-1.
REQ-019 At saturation the FSM shall return to IDLE, set o_timeout, and not publish a result.
REQ-020 i_ack with o_valid=1 clears o_valid on the next cycle; i_ack with o_valid=0 is ignored.
REQ-021 Publish and i_ack in the same cycle: the new result wins, o_valid stays 1, and o_ovf is not set.
REQ-022 Publish while o_valid=1 without i_ack shall overwrite the result and set o_ovf.
REQ-023 o_ovf and o_timeout shall clear only on reset or a rising edge of i_en.
REQ-024 i_en=0 shall force IDLE within one cycle and freeze the counter, while o_period, o_width and o_valid hold.

Reset
REQ-025 Asserting i_rst shall immediately clear the FSM to IDLE, zero the counter, o_period, o_width, o_valid, o_ovf and o_timeout, and load all synchronizer flops with 0.
REQ-026 Reset mid-measurement shall discard the partial measurement; the first result after reset requires two accepted rising edges.

Configuration
REQ-027 Macro PULSE_MEAS_GLITCH_FILTER_EN defined: an edge is accepted only after the synchronized input is stable at the new level for 3 consecutive cycles, and shorter excursions are ignored.
REQ-028 Macro undefined: accept edges per REQ-013 with no filter; measured values are identical for clean inputs in both builds, and only the absolute latency differs (by 2 cycles).

Structure
REQ-029 A shared package pulse_meas_pkg shall hold the FSM state enum, the default CNT_W, and the filter length constant 3.
REQ-030 One sub-module, pulse_meas_edge, shall contain the synchronizer, the optional filter and the rise/fall strobes; the FSM, counter and result handshake stay in pulse_meas.

Verification
REQ-031 i_sig = 10 MHz square wave, 50 % duty, i_en=1 -> after the second rising edge o_period=10, o_width=5, o_valid=1, o_ovf=0.
REQ-032 Period 37 cycles, high 12 cycles, i_ack pulsed 3 cycles after each o_valid -> every result is 37/12 and o_ovf stays 0.
REQ-033 Same stimulus, i_ack never asserted -> o_ovf=1 after the second published result, and o_period/o_width track the latest values.
REQ-034 CNT_W=8, i_sig held high after one rising edge -> o_timeout=1 after 255 cycles, FSM in IDLE, o_valid unchanged.
REQ-035 i_rst pulsed during HIGH -> all outputs are 0 immediately, and the next valid result appears only after two further rising edges.
REQ-036 With PULSE_MEAS_GLITCH_FILTER_EN, a 2-cycle glitch inside a 20-cycle low phase -> no edge accepted and the period is unchanged.

Source files
------------

// File: rtl/pulse_meas_pkg.sv
// Shared definitions for the pulse measurement block: FSM state encoding,
// the default counter width and the glitch-filter length used when
// PULSE_MEAS_GLITCH_FILTER_EN is defined.
package pulse_meas_pkg;

   // Default width of the period/width counters and results.
   localparam int CNT_W_DEF = 24;

   // Number of consecutive cycles the synchronized input must sit at a new
   // level before the filtered edge detector accepts the edge.
   localparam int FILT_LEN = 3;

   // Width of the run-length counter inside the glitch filter.
   localparam int FILT_CNT_W = $clog2(FILT_LEN);

   // Measurement FSM states. The encoding is also exported on the debug
   // state output of pulse_meas.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

endpackage

// File: rtl/pulse_meas_edge.sv
// Input conditioning for pulse_meas: SYNC_STAGES-deep synchronizer
// (SYNC_STAGES must be at least 2), optional glitch filter and one-cycle
// rise/fall strobes.
// Build option: PULSE_MEAS_GLITCH_FILTER_EN adds a stability filter that
// accepts an edge only after the synchronized input has held the new level
// for FILT_LEN consecutive cycles (2 cycles more latency than the plain
// detector, identical measured intervals for clean inputs).
module pulse_meas_edge
   import pulse_meas_pkg::*;
#(
   parameter int SYNC_STAGES = 2
)
(
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;

   // Synchronizer chain; all stages reset to 0 so a low input yields no edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

`ifdef PULSE_MEAS_GLITCH_FILTER_EN

   // Accepted (filtered) level and how many cycles in a row the synchronized
   // input has disagreed with it.
   logic                  level;
   logic [FILT_CNT_W-1:0] run;
   logic                  differs;
   logic                  accept;

   assign differs = (sync != level);
   assign accept  = differs && (run == FILT_CNT_W'(FILT_LEN - 1));

   // Run-length filter: any return to the accepted level restarts the count,
   // so excursions shorter than FILT_LEN cycles never produce an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= 1'b0;
         run   <= '0;
      end else if (!differs) begin
         run <= '0;
      end else if (accept) begin
         level <= sync;
         run   <= '0;
      end else begin
         run <= run + FILT_CNT_W'(1);
      end
   end

   assign rise = accept & sync;
   assign fall = accept & ~sync;

`else

   logic prev;

   // Previous synchronized value; an edge is any cycle where it differs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev <= 1'b0;
      end else begin
         prev <= sync;
      end
   end

   assign rise = sync & ~prev;
   assign fall = ~sync & prev;

`endif

endmodule

// File: rtl/pulse_meas.sv
// Pulse period/width meter. Measures, in i_clk cycles, the interval between
// successive accepted rising edges of i_sig (o_period) and the high time of
// the pulse that started that interval (o_width).
// Build option: PULSE_MEAS_GLITCH_FILTER_EN enables the input glitch filter
// inside pulse_meas_edge; default build has no filter.
//
// Result handshake: a result is published in the cycle the closing rising
// edge is accepted; o_valid rises on the next cycle and holds, together with
// o_period/o_width, until a cycle with i_ack=1 (o_valid drops on the cycle
// after). i_ack while o_valid=0 does nothing. If a new result is published
// while o_valid=1 and i_ack=0 the result is overwritten and o_ovf is set;
// when the publish coincides with i_ack the new result simply replaces the
// acknowledged one and o_ovf is left alone.
module pulse_meas
   import pulse_meas_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2
)
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_sig,
   input  logic             i_ack,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_width,
   output logic             o_valid,
   output logic             o_ovf,
   output logic             o_timeout,
   output logic [1:0]       o_state
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] width_cap;
   logic             rise;
   logic             fall;
   logic             en_q;
   logic             en_rise;
   logic             publish;
   logic             cap_width;
   logic             timeout_evt;

   pulse_meas_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge (
      .clk  (i_clk),
      .rst  (i_rst),
      .sig  (i_sig),
      .rise (rise),
      .fall (fall)
   );

   assign en_rise = i_en & ~en_q;
   assign o_state = state;

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, counter update and the publish/capture/timeout events.
   // Saturation is checked before counting so the counter never wraps; a
   // rising edge in the saturated cycle still closes a valid period.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      publish     = 1'b0;
      cap_width   = 1'b0;
      timeout_evt = 1'b0;
      if (!i_en) begin
         // Disabled: drop any partial measurement, counter frozen.
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rise) begin
                  state_nxt = ST_HIGH;
                  cnt_nxt   = CNT_ONE;
               end
            end
            ST_HIGH: begin
               if (cnt == CNT_MAX) begin
                  state_nxt   = ST_IDLE;
                  timeout_evt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
                  if (fall) begin
                     cap_width = 1'b1;
                     state_nxt = ST_LOW;
                  end
               end
            end
            ST_LOW: begin
               if (rise) begin
                  publish   = 1'b1;
                  state_nxt = ST_HIGH;
                  cnt_nxt   = CNT_ONE;
               end else if (cnt == CNT_MAX) begin
                  state_nxt   = ST_IDLE;
                  timeout_evt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Counter, captured width, published results and sticky status flags.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt       <= '0;
         width_cap <= '0;
         en_q      <= 1'b0;
         o_period  <= '0;
         o_width   <= '0;
         o_valid   <= 1'b0;
         o_ovf     <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         en_q <= i_en;

         if (cap_width) begin
            width_cap <= cnt;
         end

         if (publish) begin
            o_period <= cnt;
            o_width  <= width_cap;
            o_valid  <= 1'b1;
         end else if (i_ack) begin
            o_valid <= 1'b0;
         end

         // A fresh enable starts a clean status window.
         if (en_rise) begin
            o_ovf <= 1'b0;
         end else if (publish && o_valid && !i_ack) begin
            o_ovf <= 1'b1;
         end

         if (en_rise) begin
            o_timeout <= 1'b0;
         end else if (timeout_evt) begin
            o_timeout <= 1'b1;
         end
      end
   end

endmodule
